// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: reset PC, NOP encoding,
// FSM state encoding and the buffer entry layout.
package instr_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_instr_buf.sv
// instr_buf: small synchronous FIFO of {pc, instr} pairs with a same-cycle flush.
// Head is read combinationally so a pushed entry is visible the following cycle.
module instr_buf
    import instr_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic [CW-1:0] o_count
);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];
    assign do_pop  = i_pop & ~o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(i_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues credit-limited fetches, buffers
// in-order responses and drops responses made stale by an execute redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int            AW      = $clog2(BUF_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [31:0]   pcq_mem_q [BUF_DEPTH];
    logic [AW-1:0] pcq_wr_q, pcq_wr_d;
    logic [AW-1:0] pcq_rd_q, pcq_rd_d;

    fetch_entry_t  buf_head, buf_wdata;
    logic          buf_full, buf_empty, buf_push, buf_pop;
    logic [CW-1:0] buf_count;
    logic          req, issue, rsp_ok, in_fetch;

    // Credits cover both in-flight requests and buffered words, so a
    // response always finds room without a backpressure path to memory.
    assign in_fetch = (state_q == ST_FETCH);
    assign req      = in_fetch && (({1'b0, out_q} + {1'b0, buf_count}) < {1'b0, DEPTH_C});
    assign issue    = req & i_imem_gnt;
    assign rsp_ok   = i_imem_rvalid & (out_q != '0);

    assign o_valid  = ~buf_empty & ~i_redirect;
    assign buf_pop  = o_valid & i_ready;
    assign buf_push = rsp_ok & in_fetch & ~i_redirect & (~buf_full | buf_pop);

    assign buf_wdata.pc    = pcq_mem_q[pcq_rd_q];
    assign buf_wdata.instr = i_imem_rdata;

    assign o_imem_req  = req;
    assign o_imem_addr = pc_q;
    assign o_instr     = buf_empty ? NOP_INSTR : buf_head.instr;
    assign o_pc        = buf_empty ? 32'h0000_0000 : buf_head.pc;

    always_comb begin
        out_d    = out_q + CW'(issue) - CW'(rsp_ok);
        pc_d     = pc_q;
        pcq_wr_d = pcq_wr_q;
        pcq_rd_d = pcq_rd_q;
        state_d  = state_q;

        if (issue) begin
            pc_d     = pc_q + 32'd4;
            pcq_wr_d = pcq_wr_q + AW'(1);
        end
        if (rsp_ok) begin
            pcq_rd_d = pcq_rd_q + AW'(1);
        end

        unique case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            ST_DRAIN: state_d = (out_d == '0) ? ST_FETCH : ST_DRAIN;
            default:  state_d = ST_BOOT;
        endcase

        // A same-cycle issue is already counted in out_d and is treated as stale.
        if (i_redirect) begin
            pc_d    = word_align(i_redirect_pc);
            state_d = (out_d != '0) ? ST_DRAIN : ST_FETCH;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            out_q    <= '0;
            pcq_wr_q <= '0;
            pcq_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_q    <= out_d;
            pcq_wr_q <= pcq_wr_d;
            pcq_rd_q <= pcq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pcq_mem_q[pcq_wr_q] <= pc_q;
        end
    end

    instr_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_instr_buf (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_flush (i_redirect),
        .i_push  (buf_push),
        .i_data  (buf_wdata),
        .i_pop   (buf_pop),
        .o_head  (buf_head),
        .o_full  (buf_full),
        .o_empty (buf_empty),
        .o_count (buf_count)
    );

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end producer for the decode/control path: fetches 32-bit RV32I instruction words from instruction memory and delivers them to the control unit's i_instr input.
- Delivery is a valid/ready stream carrying the matching PC.
- Owns the PC and a small instruction buffer.
- Handles out-of-order-free pipelined memory responses and branch/jump redirects from execute, discarding stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries; also the maximum outstanding-plus-buffered count (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  32  fetch address, word aligned
- i_imem_gnt  in  1  memory accepts request this cycle (req & gnt = issued)
- i_imem_rvalid  in  1  response valid, in issue order, ≥1 cycle after issue
- i_imem_rdata  in  32  response instruction word
- o_valid  out  1  instruction available to decode
- i_ready  in  1  decode accepts (o_valid & i_ready = transfer)
- o_instr  out  32  instruction word to control unit
- o_pc  out  32  PC of o_instr
- i_redirect  in  1  taken branch/JAL/JALR from execute
- i_redirect_pc  in  32  redirect target

Behaviour:
- Reset (async assert, sync deassert internally):
  - pc = RESET_PC; buffer empty; outstanding = 0; state ST_BOOT.
  - o_imem_req = 0, o_imem_addr = RESET_PC, o_valid = 0, o_instr = 32'h0000_0013 (NOP), o_pc = 0.
- States:
  - ST_BOOT: one idle cycle after reset release, then ST_FETCH.
  - ST_FETCH: o_imem_req = 1 when outstanding + occupancy < BUF_DEPTH. On req & gnt: outstanding += 1, pc += 4. o_imem_addr = pc, held stable while req & !gnt.
  - ST_DRAIN: entered on a redirect with outstanding > 0, or with outstanding becoming > 0 through a same-cycle issue. o_imem_req = 0. Every rvalid is discarded and decrements outstanding. Return to ST_FETCH in the cycle after outstanding reaches 0.
- Responses:
  - In ST_FETCH, rvalid pushes {rdata, issue PC} into the buffer.
  - Issue PCs are tracked in a BUF_DEPTH-entry PC queue.
  - The credit rule guarantees the buffer never overflows. An rvalid with outstanding = 0 is a protocol error and is ignored.
- Output:
  - o_valid = buffer non-empty & !i_redirect.
  - o_instr/o_pc = buffer head; o_instr = NOP and o_pc = 0 when empty.
  - Head pops on o_valid & i_ready.
  - Latency: a response pushed in cycle N is visible on o_valid in N+1 (no bypass).
  - Simultaneous push and pop are allowed when full.
- Redirect (any state, highest priority):
  - pc = {i_redirect_pc[31:2], 2'b00}; buffer flushed the same cycle.
  - A request issued in the same cycle counts as outstanding and stale.
  - An rvalid in the same cycle is discarded.
  - Next state is ST_DRAIN if resulting outstanding > 0, else ST_FETCH.
  - A redirect while in ST_DRAIN only updates pc.
- pc wraps 32'hFFFF_FFFC → 0 silently.
- Counters: outstanding and occupancy are clog2(BUF_DEPTH)+1 bits wide.
- Reset asserted mid-operation: all state is abandoned immediately. In-flight memory responses arriving after reset release are ignored because outstanding = 0.

Decomposition:
- Shared package/header: RESET_PC default, NOP encoding 32'h0000_0013, and the state encodings ST_BOOT/ST_FETCH/ST_DRAIN.
- One natural sub-module: instr_buf, a synchronous FIFO of {pc, instr} with flush, push, pop, full, empty, parameterised by BUF_DEPTH.
- The FSM, PC, and outstanding counter live in the top.

Test Plan:
- Reset then steady stream:
  - Stimulus: gnt = 1, 1-cycle memory returning 32'h7FF00293 @0, 32'h00F29313 @4, 32'h00530333 @8; i_ready = 1.
  - Required: o_imem_req first high 1 cycle after reset release; o_instr sequence matches with o_pc 0, 4, 8; one instruction per cycle after fill.
- Backpressure:
  - Stimulus: i_ready = 0 for 6 cycles.
  - Required: at most BUF_DEPTH requests issued; o_valid stays 1; o_instr holds 32'h7FF00293; no word lost or duplicated after i_ready returns to 1.
- Grant stall:
  - Stimulus: gnt = 0 for 3 cycles with req high.
  - Required: o_imem_addr stable at 32'h0000_0004; pc advances only on the gnt cycle.
- Redirect with 2 outstanding:
  - Stimulus: 3-cycle memory latency; i_redirect with i_redirect_pc = 32'h0000_0042.
  - Required: o_valid drops the same cycle; the 2 stale responses are discarded; next request at 32'h0000_0040; first delivered instruction has o_pc = 32'h40.
- Simultaneous events:
  - Stimulus: redirect in the same cycle as rvalid and as req & gnt.
  - Required: that rvalid is dropped; the new request is counted stale; the ST_DRAIN → ST_FETCH timing is correct.
- Mid-operation reset:
  - Stimulus: assert i_rst while the buffer is full and a request is outstanding.
  - Required: outputs take reset values asynchronously; a late rvalid after release is ignored; fetch restarts at RESET_PC.
